// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through, turns loads/stores into a
// request/acknowledge data-cache transaction with lane steering and load extension.
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [1:0]      ex_op,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            mem_stall,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-1:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  output logic [7:0]      dc_wstrb,
  input  logic            dc_ack,
  input  logic [XLEN-1:0] dc_rdata,
  output logic            wb_valid,
  output logic            wb_wr_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign,
  output logic            fsm_state
);

  // Handshake: dc_req is held with stable dc_we/dc_addr/dc_wdata/dc_wstrb until the
  // cycle dc_ack is high; that cycle completes the transfer and dc_rdata is sampled.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state, state_next;
  logic            is_mem, misalign, accept, mem_go, flush_any;
  logic [7:0]      strb;
  logic            r_we, r_uns, r_flush;
  logic [1:0]      r_size;
  logic [2:0]      r_off;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_addr, r_wdata, shifted, load_ext;
  logic [7:0]      r_wstrb;

  always_comb begin
    is_mem = (ex_op == 2'd1) || (ex_op == 2'd2);
    case (ex_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = ex_addr[0];
      2'd2:    misalign = |ex_addr[1:0];
      default: misalign = |ex_addr[2:0];
    endcase
    case (ex_size)
      2'd0:    strb = 8'h01 << ex_addr[2:0];
      2'd1:    strb = 8'h03 << ex_addr[2:0];
      2'd2:    strb = 8'h0F << ex_addr[2:0];
      default: strb = 8'hFF;
    endcase
    accept    = (state == IDLE) && ex_valid && !flush;
    mem_go    = accept && is_mem && !misalign;
    flush_any = r_flush || flush;
  end

  always_comb begin
    shifted = dc_rdata >> {r_off, 3'b000};
    case (r_size)
      2'd0:    load_ext = r_uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = r_uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = r_uns ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_go) state_next = REQ;
      REQ:     if (dc_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = (state == REQ);
    dc_req    = (state == REQ);
    dc_we     = dc_req && r_we;
    dc_addr   = dc_req ? r_addr  : '0;
    dc_wdata  = dc_req ? r_wdata : '0;
    dc_wstrb  = dc_req ? r_wstrb : '0;
    fsm_state = (state == REQ);
  end

  // Request registers are loaded at acceptance so the cache sees values that do not
  // follow the (possibly changing) execute outputs while the transaction is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we <= 1'b0; r_uns <= 1'b0; r_flush <= 1'b0; r_size <= '0; r_off <= '0;
      r_rd <= '0; r_addr <= '0; r_wdata <= '0; r_wstrb <= '0;
      wb_valid <= 1'b0; wb_wr_en <= 1'b0; wb_rd <= '0; wb_data <= '0; wb_misalign <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_wr_en    <= 1'b0;
      wb_misalign <= 1'b0;
      if (state == IDLE) begin
        if (mem_go) begin
          r_we    <= (ex_op == 2'd2);
          r_uns   <= ex_unsigned;
          r_size  <= ex_size;
          r_off   <= ex_addr[2:0];
          r_rd    <= ex_rd;
          r_addr  <= {ex_addr[XLEN-1:3], 3'b000};
          r_wdata <= ex_store_data << {ex_addr[2:0], 3'b000};
          r_wstrb <= strb;
          r_flush <= 1'b0;
        end else if (accept) begin
          wb_valid    <= 1'b1;
          wb_rd       <= ex_rd;
          wb_data     <= is_mem ? '0 : ex_result;
          wb_wr_en    <= !is_mem && (ex_rd != 5'd0);
          wb_misalign <= is_mem;
        end
      end else begin
        if (flush) r_flush <= 1'b1;
        if (dc_ack && !flush_any) begin
          wb_valid <= 1'b1;
          wb_rd    <= r_rd;
          wb_data  <= r_we ? '0 : load_ext;
          wb_wr_en <= !r_we && (r_rd != 5'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random mixed traffic, with writebacks
// checked against an expected queue filled as each instruction is driven.
module tb_mem_stage;
  localparam int XLEN = 64;

  logic            clk, reset;
  logic            ex_valid, ex_unsigned, flush, dc_ack;
  logic [1:0]      ex_op, ex_size;
  logic [63:0]     ex_addr, ex_store_data, ex_result, dc_rdata;
  logic [4:0]      ex_rd;
  logic            mem_stall, dc_req, dc_we, wb_valid, wb_wr_en, wb_misalign, fsm_state;
  logic [63:0]     dc_addr, dc_wdata, wb_data;
  logic [7:0]      dc_wstrb;
  logic [4:0]      wb_rd;

  int vectors = 0;
  int miscompares = 0;
  logic [70:0] exp_q[$];   // {misalign, wr_en, rd, data}
  logic [70:0] mon_e;

  mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_result(ex_result), .ex_rd(ex_rd), .flush(flush), .mem_stall(mem_stall),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_ack(dc_ack), .dc_rdata(dc_rdata), .wb_valid(wb_valid),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_op = 2'd0; ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = '0;
    ex_store_data = '0; ex_result = '0; ex_rd = '0; flush = 1'b0; dc_ack = 1'b0; dc_rdata = '0;
  endtask

  // reference model
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
    int n;
    logic [63:0] v;
    logic s;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(int'(off)+i) +: 8];
    s = v[8*n-1];
    if (!uns && size != 2'd3)
      for (int i = n; i < 8; i++) v[8*i +: 8] = {8{s}};
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < (1 << size); i++) m[int'(off)+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sdata, input logic [2:0] off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8 - int'(off); i++) w[8*(int'(off)+i) +: 8] = sdata[8*i +: 8];
    return w;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_ctl", {57'd0, wb_misalign, wb_wr_en, wb_rd}, {57'd0, mon_e[70:64]});
          if (!mon_e[70]) check("wb_data", wb_data, mon_e[63:0]);
        end
      end else begin
        check("wb_idle", {62'd0, wb_wr_en, wb_misalign}, 64'd0);
      end
    end
  end

  // driver tasks: each starts in the cycle where the instruction is presented
  task automatic alu_op(input logic [1:0] op, input logic [4:0] rd, input logic [63:0] res,
                        input logic flush_it);
    ex_valid = 1'b1; ex_op = op; ex_rd = rd; ex_result = res; flush = flush_it;
    ex_addr = {$urandom, $urandom}; ex_size = 2'($urandom_range(0, 3));
    if (!flush_it) exp_q.push_back({1'b0, rd != 5'd0, rd, res});
    check("alu_stall", {63'd0, mem_stall}, 64'd0);
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    check("alu_noreq", {63'd0, dc_req}, 64'd0);
    check("alu_wb_valid", {63'd0, wb_valid}, {63'd0, !flush_it});
  endtask

  task automatic mis_op(input logic [1:0] size, input logic [63:0] addr, input logic store,
                        input logic [4:0] rd);
    ex_valid = 1'b1; ex_op = store ? 2'd2 : 2'd1; ex_size = size; ex_addr = addr; ex_rd = rd;
    exp_q.push_back({1'b1, 1'b0, rd, 64'd0});
    tick();
    ex_valid = 1'b0;
    check("mis_noreq", {63'd0, dc_req}, 64'd0);
  endtask

  task automatic mem_op(input logic store, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input int k, input logic [4:0] rd,
                        input int flush_at, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_wb);
    ex_valid = 1'b1; ex_op = store ? 2'd2 : 2'd1; ex_size = size; ex_unsigned = uns;
    ex_addr = addr; ex_store_data = sdata; ex_rd = rd; flush = 1'b0;
    if (flush_at == 0)
      exp_q.push_back({1'b0, !store && rd != 5'd0, rd, store ? 64'd0 : exp_wb});
    tick();
    for (int c = 1; c <= k; c++) begin
      // stray instruction while stalled; it must be ignored
      ex_valid = 1'b1; ex_op = 2'd0; ex_rd = 5'd7; ex_result = {$urandom, $urandom};
      ex_store_data = ~sdata; ex_addr = addr ^ 64'h48;
      flush = (c == flush_at);
      dc_ack = (c == k); dc_rdata = rdata;
      check("mem_req", {62'd0, dc_req, mem_stall}, 64'd3);
      check("mem_we", {63'd0, dc_we}, {63'd0, store});
      check("mem_addr", dc_addr, {addr[63:3], 3'b000});
      if (store) begin
        check("mem_wstrb", {56'd0, dc_wstrb}, {56'd0, exp_strb});
        check("mem_wdata", dc_wdata, exp_wdata);
      end
      tick();
    end
    ex_valid = 1'b0; flush = 1'b0; dc_ack = 1'b0; dc_rdata = {$urandom, $urandom};
    check("mem_release", {62'd0, dc_req, mem_stall}, 64'd0);
    check("mem_wb_valid", {63'd0, wb_valid}, {63'd0, flush_at == 0});
  endtask

  initial begin
    logic [63:0] a, sd, rd_data;
    logic [1:0]  sz;
    logic        st, un;
    int          k, fa, sel;

    drive_idle();
    reset = 1'b1;
    repeat (2) tick();
    check("rst_ctl", {56'd0, mem_stall, dc_req, dc_we, wb_valid, wb_wr_en, wb_misalign,
                      fsm_state, 1'b0}, 64'd0);
    check("rst_dc_addr", dc_addr, 64'd0);
    check("rst_dc_wdata", dc_wdata, 64'd0);
    check("rst_dc_wstrb", {56'd0, dc_wstrb}, 64'd0);
    check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    reset = 1'b0;
    tick();

    // ALU pass-through
    alu_op(2'd0, 5'd5, 64'h1234, 1'b0);
    tick();
    // signed / unsigned byte load, ack in cycle 3
    mem_op(1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'h00000000_80000000, 3, 5'd4, 0,
           8'h00, 64'd0, 64'hFFFFFFFF_FFFFFF80);
    mem_op(1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h00000000_80000000, 3, 5'd4, 0,
           8'h00, 64'd0, 64'h80);
    // halfword store, ack in cycle 1
    mem_op(1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 64'd0, 1, 5'd9, 0,
           8'hC0, 64'hBEEF0000_00000000, 64'd0);
    // misaligned word load
    mis_op(2'd2, 64'h3002, 1'b0, 5'd3);
    tick();
    // flush during a load, ack held off until cycle 4
    mem_op(1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 64'h1122334455667788, 4, 5'd6, 2,
           8'h00, 64'd0, 64'h1122334455667788);
    // load to rd 0
    mem_op(1'b0, 2'd2, 1'b0, 64'h5004, 64'd0, 64'h87654321_00000000, 2, 5'd0, 0,
           8'h00, 64'd0, 64'hFFFFFFFF_87654321);
    // flush with ex_valid in IDLE, then back-to-back ALU ops including reserved op
    alu_op(2'd0, 5'd8, 64'hDEAD, 1'b1);
    alu_op(2'd3, 5'd1, 64'hCAFEF00D_12345678, 1'b0);
    alu_op(2'd0, 5'd0, 64'h55, 1'b0);
    alu_op(2'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // reset in cycle 2 of a pending load; a late ack must be ignored
    ex_valid = 1'b1; ex_op = 2'd1; ex_size = 2'd3; ex_addr = 64'h6000; ex_rd = 5'd2;
    tick();
    ex_valid = 1'b0;
    check("rstreq_req", {63'd0, dc_req}, 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; dc_ack = 1'b1; dc_rdata = 64'h1;
    check("rstreq_state", {61'd0, dc_req, mem_stall, fsm_state}, 64'd0);
    tick();
    dc_ack = 1'b0;
    check("rstreq_nowb", {63'd0, wb_valid}, 64'd0);
    tick();

    // random mixed traffic
    repeat (80) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        alu_op($urandom_range(0, 1) ? 2'd3 : 2'd0, 5'($urandom_range(0, 31)),
               {$urandom, $urandom}, (sel == 0) && ($urandom_range(0, 2) == 0));
      end else if (sel <= 7) begin
        sz = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom};
        a[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
        st = 1'($urandom_range(0, 1));
        un = 1'($urandom_range(0, 1));
        sd = {$urandom, $urandom};
        rd_data = {$urandom, $urandom};
        k = $urandom_range(1, 3);
        fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, k) : 0;
        mem_op(st, sz, un, a, sd, rd_data, k, 5'($urandom_range(0, 31)), fa,
               model_strb(a[2:0], sz), model_wdata(sd, a[2:0]),
               model_load(rd_data, a[2:0], sz, un));
      end else begin
        sz = 2'($urandom_range(1, 3));
        a = {$urandom, $urandom};
        a[2:0] = 3'($urandom_range(0, 7));
        a[0] = (sz == 2'd1) ? 1'b1 : a[0];
        if (a[2:0] == 3'd0 || (sz == 2'd2 && a[1:0] == 2'd0)) a[0] = 1'b1;
        mis_op(sz, a, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end
      if ($urandom_range(0, 3) == 0) tick();
    end

    drive_idle();
    repeat (4) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the ALU/execute stage and upstream of register writeback. It accepts one executed instruction at a time. Non-memory results pass through with one cycle of latency. Loads and stores become a request/acknowledge transaction on the data-cache port, with byte-lane steering, sign/zero extension and an upstream stall while the transaction is in flight.

## Interface
- XLEN, 64: datapath and address width; the only supported value is 64.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute stage presents an instruction this cycle
- ex_op  in  2  0 = no memory access (ALU result), 1 = load, 2 = store, 3 = reserved (treated as 0)
- ex_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- ex_unsigned  in  1  load zero-extends (lbu/lhu/lwu) when 1
- ex_addr  in  64  effective address (already computed by execute)
- ex_store_data  in  64  store source value, right-aligned
- ex_result  in  64  ALU result for non-memory instructions
- ex_rd  in  5  destination register
- flush  in  1  squash the current/in-flight instruction's writeback
- mem_stall  out  1  execute must hold its outputs and must not present a new instruction
- dc_req  out  1  data-cache request valid
- dc_we  out  1  1 = store
- dc_addr  out  64  {ex_addr[63:3], 3'b000}
- dc_wdata  out  64  lane-shifted store data
- dc_wstrb  out  8  byte enables
- dc_ack  in  1  one-cycle pulse that completes the request; dc_rdata is valid with it
- dc_rdata  in  64  aligned 8-byte load data
- wb_valid  out  1  writeback slot valid (one-cycle pulse per instruction)
- wb_wr_en  out  1  write register file
- wb_rd  out  5  destination register
- wb_data  out  64  writeback value
- wb_misalign  out  1  misaligned access flagged on this writeback

## Operation
- FSM states: IDLE and REQ.
- In IDLE with ex_valid = 1, the stage captures all ex_* inputs.
  - Non-memory op, or a misaligned memory op: stay in IDLE and produce the writeback next cycle.
  - Aligned load or store: go to REQ.
- Misaligned means half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, or double with addr[2:0] ≠ 0. A misaligned op issues no dc_req and produces wb_misalign = 1 and wb_wr_en = 0.
- In REQ, dc_req = 1 and dc_we/dc_addr/dc_wdata/dc_wstrb are stable, driven from registered values. dc_ack = 1 returns the FSM to IDLE and produces the writeback next cycle.
- mem_stall = (state == REQ), combinational from state. ex_valid is ignored while in REQ, including the ack cycle.
- Store byte enables:
  - byte: 8'h01 << addr[2:0]
  - half: 8'h03 << addr[2:0]
  - word: 8'h0F << addr[2:0]
  - double: 8'hFF
  - dc_wdata = ex_store_data << (8*addr[2:0]).
- Load data: shifted = dc_rdata >> (8*addr[2:0]). Truncate to the access size, then sign-extend, or zero-extend when ex_unsigned = 1. A double load ignores ex_unsigned.
- Writeback contents:
  - Non-memory op: wb_data = ex_result.
  - Load: wb_data = the extended load data.
  - Store: wb_data = 0.
  - wb_wr_en = 1 only for a valid non-memory op or load, with rd ≠ 0, not flushed and not misaligned.
- Flush:
  - Asserted in IDLE together with ex_valid: nothing is captured and there is no writeback.
  - Asserted at any cycle while in REQ: the transaction still completes (a store is never cancelled), but the resulting wb_valid = 0.
- Reserved ex_op = 3 behaves as a non-memory op.

## Timing
- Reset values: state = IDLE, and every output is 0 (mem_stall, dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb, wb_valid, wb_wr_en, wb_rd, wb_data, wb_misalign).
- Reset during REQ drops the request the next cycle and discards any pending writeback and flush flag.
- Non-memory or misaligned op: accepted in cycle 0, wb_valid in cycle 1. Back-to-back acceptance every cycle is allowed.
- Memory op accepted in cycle 0:
  - dc_req rises in cycle 1.
  - If dc_ack arrives in cycle k ≥ 1, dc_req falls in cycle k+1 and wb_valid is in cycle k+1.
  - A new instruction can be accepted in cycle k+1.
  - Minimum load-to-writeback latency is 2 cycles.
- dc_ack while not in REQ is ignored.
- All wb_* outputs are registered; wb_valid is a single-cycle pulse.

## Test plan
- ALU pass-through: ex_op = 0, rd = 5, ex_result = 0x1234 in cycle 0 → cycle 1: wb_valid = 1, wb_wr_en = 1, wb_rd = 5, wb_data = 0x1234, mem_stall = 0 throughout.
- Signed byte load: addr = 0x1003, size = 0, unsigned = 0, dc_rdata = 0x00000000_80000000 with ack in cycle 3 →
  - dc_req high in cycles 1–3, dc_addr = 0x1000
  - cycle 4: wb_data = 0xFFFFFFFF_FFFFFF80
  - the same load with unsigned = 1 → wb_data = 0x80.
- Halfword store: addr = 0x2006, data = 0xBEEF, ack in cycle 1 → dc_we = 1, dc_wstrb = 0xC0, dc_wdata = 0xBEEF0000_00000000; cycle 2: wb_valid = 1, wb_wr_en = 0.
- Misaligned word load at 0x3002 → no dc_req ever; cycle 1: wb_valid = 1, wb_misalign = 1, wb_wr_en = 0.
- Flush during a load: flush asserted in cycle 2 while dc_ack is held off until cycle 4 → dc_req stays high through cycle 4, wb_valid = 0 in cycle 5. A new ex_valid presented in cycles 1–4 is ignored.
- rd = 0 load and reset mid-REQ:
  - A load to rd = 0 → wb_valid = 1, wb_wr_en = 0.
  - reset asserted in cycle 2 of a pending load → cycle 3: dc_req = 0, state IDLE, no writeback.
